mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle signed 16×16 multiplier for the RISC-Z execute stage. It uses radix-2 Booth recoding and one 17-bit add/subtract step per cycle, which keeps the area close to a single adder. The control unit issues a start pulse and stalls the pipeline on `busy`. It collects the 32-bit product when `done` pulses.

## Interface
- `WIDTH`, default 16: operand width. The product is 2·WIDTH bits and the iteration count is WIDTH.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: step enable. When low, all state freezes; this is the pipeline stall.
- `clear` in 1: synchronous abort that returns the block to IDLE.
- `start` in 1: launch request, sampled only in IDLE or DONE.
- `a` in WIDTH: signed multiplicand, latched on an accepted start.
- `b` in WIDTH: signed multiplier, latched on an accepted start.
- `busy` out 1: high while iterating.
- `done` out 1: one-cycle pulse when the product becomes valid.
- `product` out 2·WIDTH: signed product, held until the next accepted start.

## Operation
- **States:**
  - IDLE: the block waits for `start`.
  - CALC: WIDTH Booth iterations.
  - DONE: a single cycle with `done`=1.
- **IDLE/DONE → CALC:** on `start`=1 and `enable`=1, the block:
  - latches M=`a`;
  - sets Q=`b`, A=0 (WIDTH+1 bits sign-extended), q₋₁=0, cnt=0.
- **CALC step** (only when `enable`=1), based on the pair {Q[0], q₋₁}:
  - 01: A=A+M.
  - 10: A=A−M.
  - 00 or 11: no add.
  - Then arithmetic-shift {A,Q,q₋₁} right by 1 and increment cnt.
- **CALC → DONE:** after the step where cnt reaches WIDTH−1. On that edge, `product`={A[WIDTH-1:0],Q} taken from the post-shift value.
- **DONE → IDLE:** on the next enabled cycle if `start`=0. DONE with `start`=1 goes directly to CALC (back-to-back operation).
- **Arithmetic:** M is sign-extended to WIDTH+1 before every add or subtract, so −32768·−32768 = +2³⁰ is exact. The product is two's complement and never saturates.
- **Start while busy:** `start` in CALC is ignored, with no queueing.
- **Clear:** `clear`=1 has priority over `start` and `enable`. It forces IDLE and drops `busy`/`done`, and `product` is unchanged.
- **Reset mid-operation:** asynchronous return to IDLE with all registers zeroed.

## Timing
- **Reset values:** `busy`=0, `done`=0, `product`=0, state=IDLE, cnt=0, A/Q/M/q₋₁=0.
- **Latency**, with start accepted at edge 0 and `enable` held high:
  - `busy` is high after edges 0…15.
  - `done`=1 and `product` is valid after edge 16.
  - The total is WIDTH+1 cycles.
- **Stall:** each enable-low cycle in CALC adds one cycle of latency. During DONE, `enable`=0 holds `done` high until the next enabled edge.
- **Output decoding:** `busy` = (state==CALC) and `done` = (state==DONE), both decoded directly from the registered state. `product` changes only on the CALC→DONE edge or on reset.
- **Combinational paths:** none from inputs to outputs.

## Structure
- **Package `riscz_pkg`:**
  - state enum `mul_state_t` {IDLE, CALC, DONE};
  - `MUL_WIDTH` = 16;
  - the cnt width, $clog2(WIDTH).
- **Sub-module `booth_step`** (combinational): inputs A, Q, q₋₁, M; outputs the next A, Q, q₋₁. It contains the WIDTH+1-bit add/subtract and the arithmetic shift.
- **Top level:** FSM, counter, and operand/product registers only.

## Test plan
- **Basic signed multiply:** `a`=3, `b`=4 with start at edge 0 → `done` after edge 16, `product`=0x0000_000C, and `busy` high for exactly 16 cycles.
- **Sign corners:**
  - `a`=0x8000, `b`=0x8000 → 0x4000_0000;
  - `a`=0xFFFF, `b`=0x0001 → 0xFFFF_FFFF;
  - `a`=0x7FFF, `b`=0x8000 → 0xC000_8000.
- **Stall and ignored start:**
  - `enable` low for 5 cycles mid-CALC → `done` after edge 21;
  - `start` pulsed during CALC → ignored, and the result matches the original operands.
- **Back-to-back:** `start` held high in DONE with new operands 7 and −2 → the next `done` is 17 cycles later with `product`=0xFFFF_FFF2.
- **Abort and reset:**
  - `clear` at cycle 8 → IDLE on the next edge, `busy`=0, `done` never pulses, `product` keeps its previous value;
  - `reset_n` low asynchronously mid-CALC → all outputs 0 immediately.
- **Random:** 1000 random signed operand pairs compared against a reference model, with random `enable` gaps.

Source files
------------

// File: rtl/riscz_pkg.sv
// Shared types and constants for the RISC-Z execute-stage multiplier.
package riscz_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Iteration counter width for a given operand width (never narrower than 1 bit).
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the WIDTH+1-bit accumulator, then an arithmetic right shift of {A,Q,q-1}.
module booth_step #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH:0]   i_a,
  input  logic        [WIDTH-1:0] i_q,
  input  logic                    i_qm1,
  input  logic signed [WIDTH-1:0] i_m,
  output logic signed [WIDTH:0]   o_a,
  output logic        [WIDTH-1:0] o_q,
  output logic                    o_qm1
);

  logic signed [WIDTH:0] w_m_ext;
  logic signed [WIDTH:0] w_sum;

  // The extra accumulator bit keeps -2^(W-1) * -2^(W-1) from overflowing.
  assign w_m_ext = {i_m[WIDTH-1], i_m};

  // Booth recoding of the current bit pair selects add, subtract or pass.
  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_qm1})
      2'b01:   w_sum = i_a + w_m_ext;
      2'b10:   w_sum = i_a - w_m_ext;
      default: w_sum = i_a;
    endcase
  end

  assign o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_qm1 = i_q[0];

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle signed WIDTHxWIDTH Booth multiplier: FSM, iteration counter and
// operand/product registers around a single combinational Booth step.
module mul_sequencer
  import riscz_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t r_state;
  mul_state_t w_next_state;

  logic        [CNT_W-1:0]   r_cnt;
  logic signed [WIDTH:0]     r_acc;
  logic        [WIDTH-1:0]   r_q;
  logic                      r_qm1;
  logic signed [WIDTH-1:0]   r_m;
  logic        [2*WIDTH-1:0] r_product;

  logic signed [WIDTH:0]     w_acc_nxt;
  logic        [WIDTH-1:0]   w_q_nxt;
  logic                      w_qm1_nxt;
  logic                      w_last;
  logic                      w_accept;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_booth_step (
    .i_a   (r_acc),
    .i_q   (r_q),
    .i_qm1 (r_qm1),
    .i_m   (r_m),
    .o_a   (w_acc_nxt),
    .o_q   (w_q_nxt),
    .o_qm1 (w_qm1_nxt)
  );

  assign w_last   = (r_cnt == CNT_LAST);
  assign w_accept = !clear && enable && start && ((r_state == IDLE) || (r_state == DONE));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: clear wins over everything, enable low freezes the FSM.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = IDLE;
    end else if (enable) begin
      case (r_state)
        IDLE:    if (start) w_next_state = CALC;
        CALC:    if (w_last) w_next_state = DONE;
        DONE:    w_next_state = start ? CALC : IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Operand load, per-cycle Booth iteration, and product capture on the final step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_product <= '0;
    end else if (!clear && enable) begin
      if (w_accept) begin
        r_m   <= a;
        r_q   <= b;
        r_acc <= '0;
        r_qm1 <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        r_qm1 <= w_qm1_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_product <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
        end
      end
    end
  end

  assign busy    = (r_state == CALC);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule
